// File: rtl/mul_div_unit.sv
// mul_div_unit: radix-2 multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
module mul_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  mthi,
  input  logic                  mtlo,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] acc, mul_next, div_next, prod;
  logic [W-1:0] mag_a, mag_b, mag_a_in, mag_b_in, div_sub, q_fix, r_fix, a_orig;
  logic [W:0] mul_sum;
  logic is_div, neg_q, neg_r, sa, sb, div_ge;
  assign sa = op[0] & A[W-1];
  assign sb = op[0] & B[W-1];
  assign mag_a_in = sa ? -A : A;
  assign mag_b_in = sb ? -B : B;
  assign busy = state != IDLE;
  // multiply: add multiplicand on multiplier LSB, then shift the 65-bit result right
  assign mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_a} : {(W+1){1'b0}});
  assign mul_next = {mul_sum, acc[W-1:1]};
  // divide: the shifted partial remainder needs W+1 bits before the trial subtract
  assign div_ge = acc[2*W-1:W-1] >= {1'b0, mag_b};
  assign div_sub = acc[2*W-2:W-1] - mag_b;
  assign div_next = div_ge ? {div_sub, acc[W-2:0], 1'b1} : {acc[2*W-2:0], 1'b0};
  assign prod = neg_q ? -acc : acc;
  assign q_fix = neg_q ? -acc[W-1:0] : acc[W-1:0];
  assign r_fix = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
  assign a_orig = neg_r ? -mag_a : mag_a;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = start ? RUN : IDLE;
    else if (state == RUN) state_n = (cnt == CW'(W-1)) ? FIX : RUN;
    else state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      acc <= '0;
      cnt <= '0;
      mag_a <= '0;
      mag_b <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      done <= 1'b0;
      div_by_zero <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          is_div <= op[1];
          mag_a <= mag_a_in;
          mag_b <= mag_b_in;
          neg_q <= sa ^ sb;
          neg_r <= sa;
          cnt <= '0;
          acc <= {{W{1'b0}}, op[1] ? mag_a_in : mag_b_in};
        end else begin
          if (mthi) HI <= A;
          if (mtlo) LO <= A;
        end
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        acc <= is_div ? div_next : mul_next;
      end else begin
        done <= 1'b1;
        div_by_zero <= is_div && mag_b == '0;
        HI <= !is_div ? prod[2*W-1:W] : (mag_b == '0) ? a_orig : r_fix;
        LO <= !is_div ? prod[W-1:0] : (mag_b == '0) ? {W{1'b1}} : q_fix;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed checks of mul_div_unit results, latency, handshake and reset
module tb_mul_div_unit;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] A = '0, B = '0;
  logic busy, done, div_by_zero;
  logic [31:0] HI, LO;
  logic [31:0] hi_prev = '0, lo_prev = '0;
  int checks = 0, errors = 0;
  mul_div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                        input bit mt, input int inj);
    int n;
    bit bad;
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1; mtlo = mt;
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0; A = $urandom; B = $urandom; op = ~o;
    chk({tag, " busy_e0"}, 64'(busy), 64'd1);
    n = 0;
    bad = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (!busy) bad = 1;
      if (n == 16) begin
        chk({tag, " hi_hold"}, 64'(HI), 64'(hi_prev));
        chk({tag, " lo_hold"}, 64'(LO), 64'(lo_prev));
      end
      if (n == inj - 1) begin
        start = 1'b1; op = 2'b10; A = 32'd9; B = 32'd3; mthi = 1'b1;
      end else if (n == inj) begin
        start = 1'b0; mthi = 1'b0;
      end
    end
    chk({tag, " latency"}, 64'(n), 64'd33);
    chk({tag, " busy_run"}, 64'(bad), 64'd0);
    chk({tag, " busy_done"}, 64'(busy), 64'd0);
    chk({tag, " HI"}, 64'(HI), 64'(ehi));
    chk({tag, " LO"}, 64'(LO), 64'(elo));
    chk({tag, " dbz"}, 64'(div_by_zero), 64'(edbz));
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
    chk({tag, " dbz_after"}, 64'(div_by_zero), 64'd0);
    hi_prev = ehi;
    lo_prev = elo;
  endtask
  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst dbz", 64'(div_by_zero), 64'd0);
    chk("rst HI", 64'(HI), 64'd0);
    chk("rst LO", 64'(LO), 64'd0);
    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0, 0);
    run_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0, 0);
    run_op("divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0, 0);
    run_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0, 0);
    run_op("div_zero", 2'b11, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 1'b1, 0, 0);
    run_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0, 0);
    run_op("mult_inj", 2'b01, 32'd5, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF6, 1'b0, 0, 5);
    @(negedge clk);
    A = 32'hCAFEF00D; mthi = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0;
    chk("mthi HI", 64'(HI), 64'hCAFEF00D);
    chk("mthi LO", 64'(LO), 64'(lo_prev));
    chk("mthi done", 64'(done), 64'd0);
    hi_prev = 32'hCAFEF00D;
    run_op("start_mtlo", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1, 0);
    @(negedge clk);
    op = 2'b10; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid busy", 64'(busy), 64'd0);
    chk("rst_mid HI", 64'(HI), 64'd0);
    chk("rst_mid LO", 64'(LO), 64'd0);
    chk("rst_mid done", 64'(done), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    chk("rst_mid no_done", 64'(seen), 64'd0);
    hi_prev = '0;
    lo_prev = '0;
    run_op("multu_6x7", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Multi-cycle MULT/MULTU/DIV/DIVU unit that owns the architectural HI/LO registers of the MIPS datapath. It sits beside the single-cycle ALU: it takes the same rs/rt operands as A/B and returns results through HI/LO for MFHI/MFLO. A start/busy/done handshake lets the control unit stall while it iterates. It is radix-2: shift-add for multiply, restoring for divide, with a sign-fix step for the signed operations.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width; the iteration count equals DATA_WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
A  input  32  rs operand: multiplicand or dividend; also the MTHI/MTLO data
B  input  32  rt operand: multiplier or divisor
mthi  input  1  write A to HI; honoured only in IDLE
mtlo  input  1  write A to LO; honoured only in IDLE
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse when HI/LO take a result
div_by_zero  output  1  valid with done; high for DIV/DIVU with B==0
HI  output  32  upper product word or remainder
LO  output  32  lower product word or quotient

Behaviour:
- Reset, at any time including mid-operation:
  - state=IDLE; HI=LO=0; busy=done=div_by_zero=0.
  - The operation in flight is discarded and no done pulse follows.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - start=1 at edge E0: latch op, |A| and |B| (two's-complement magnitude for signed ops, raw for unsigned), and the result signs.
  - Clear the counter; go to RUN. busy=1 from E0.
  - start has priority over mthi/mtlo in the same cycle; the mthi/mtlo writes are dropped.
  - With no start, mthi/mtlo write A into HI/LO at the edge. Both may be asserted together. done is not pulsed.
- RUN: 32 cycles, edges E1..E32, one iteration per edge. At E32 go to FIX.
  - Multiply: a 64-bit product accumulator. Add the multiplicand when the current multiplier LSB is 1, then shift right.
  - Divide: a 64-bit remainder/quotient register. Shift left, trial-subtract the divisor, keep the result if non-negative and set quotient bit 1.
- FIX, edge E33:
  - Apply sign correction, write HI/LO, drive done=1 for one cycle, set busy=0, return to IDLE.
  - Total latency: done is high during the cycle after E33, i.e. 33 edges after the start-sampling edge. HI/LO hold the new values from E33.
- Sign rules:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient is negative if the signs differ; remainder takes the dividend's sign (truncating division).
  - The MULTU/DIVU path never negates.
- Divide by zero (B==0 on DIV/DIVU):
  - Same latency; iterations may run or be skipped, but done still fires at E33.
  - Result: HI=A unmodified, LO=32'hFFFFFFFF, div_by_zero=1 during the done cycle.
  - div_by_zero is 0 on all other done cycles and whenever done=0.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No flag.
- Signals ignored while busy=1: start, mthi, mtlo. HI/LO keep their old values until E33.
- Back-to-back: start may be asserted in the done cycle. FSM is in IDLE, so it is accepted and E0 is that edge.
- A, B and op are don't-care after E0; the unit works from its latched copies.

Test Plan:
1. MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> done one cycle, 33 edges after start; HI=0xFFFFFFFE, LO=0x00000001; busy high from E0 through E32.
2. MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
3. DIVU A=100, B=7 -> LO=14, HI=2. DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
4. DIV A=0x12345678, B=0 -> HI=0x12345678, LO=0xFFFFFFFF, div_by_zero=1 with done. Also DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, div_by_zero=0.
5. Handshake and MT writes:
   - MULT running; pulse start with a new op at E5 -> ignored; only the original result appears, at E33.
   - mthi in IDLE with A=0xCAFEF00D -> HI=0xCAFEF00D next edge, no done.
   - start+mtlo in the same cycle -> LO unchanged until the result.
6. Reset mid-operation: assert reset at E10 of a DIVU -> next edge busy=0, HI=LO=0, no done pulse. A new MULTU 6*7 then completes with LO=42, HI=0.
